miniscope_ctrl: RTL

Sequencer for the miniscope storage RAM, which is 2048 bx deep and 16 bits wide. It drives the RAM write port as a free-running circular buffer that advances one address per bx. On each pretrigger event it latches a look-back base address, and on a readout request from the DMB readout sequencer it generates a burst of read addresses. It sits between the sequencer/DMB readout logic and the miniscope RAM block, and supplies `fifo_wen`, `fifo_wadr_mini` and `fifo_radr_mini` plus read framing strobes.

---
 rtl/miniscope_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/miniscope_ctrl.sv
// Miniscope RAM sequencer: circular write pointer, pretrigger base capture and read burst generation.
// Optional build macro MINISCOPE_OVFCNT_EN enables the saturating dropped-trigger counter.
module miniscope_ctrl #(
    parameter int RAM_ADRB  = 11,
    parameter int TBIN_BITS = 5
) (
    input  logic                 clock,
    input  logic                 global_reset,
    input  logic                 mini_en,
    input  logic [TBIN_BITS-1:0] mini_tbins,
    input  logic [TBIN_BITS-1:0] mini_tbins_pre,
    input  logic [RAM_ADRB-1:0]  wr_offset,
    input  logic                 trig_in,
    input  logic                 rd_start,
    output logic                 fifo_wen,
    output logic [RAM_ADRB-1:0]  fifo_wadr_mini,
    output logic [RAM_ADRB-1:0]  fifo_radr_mini,
    output logic                 mini_rd_busy,
    output logic                 mini_rd_valid,
    output logic                 mini_rd_last,
    output logic                 mini_rd_done,
    output logic                 mini_rd_empty,
    output logic                 evt_pending,
    output logic                 evt_overflow,
    output logic [7:0]           overflow_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        FLUSH = 2'd2
    } rd_state_t;

    rd_state_t             state;
    rd_state_t             state_next;
    logic [RAM_ADRB-1:0]   base_pending;
    logic [RAM_ADRB-1:0]   new_base;
    logic [TBIN_BITS-1:0]  word_cnt;
    logic [TBIN_BITS-1:0]  tbins_lat;
    logic                  accept;
    logic                  capture;
    logic                  last_issue;

    assign new_base   = fifo_wadr_mini - wr_offset - RAM_ADRB'(mini_tbins_pre);
    assign capture    = trig_in && mini_en;
    assign last_issue = (state == READ) && (word_cnt == tbins_lat - TBIN_BITS'(1));

    always_ff @(posedge clock) begin
        if (global_reset) state <= IDLE;
        else              state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (rd_start && evt_pending) begin
                    accept = 1'b1;
                    // A zero-length burst consumes the event but never leaves IDLE.
                    if (mini_tbins != '0) state_next = READ;
                end
            end
            READ:    if (last_issue) state_next = FLUSH;
            FLUSH:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (global_reset) begin
            fifo_wen       <= 1'b0;
            fifo_wadr_mini <= '0;
            fifo_radr_mini <= '0;
            mini_rd_busy   <= 1'b0;
            mini_rd_valid  <= 1'b0;
            mini_rd_last   <= 1'b0;
            mini_rd_done   <= 1'b0;
            mini_rd_empty  <= 1'b0;
            evt_pending    <= 1'b0;
            evt_overflow   <= 1'b0;
            base_pending   <= '0;
            word_cnt       <= '0;
            tbins_lat      <= '0;
        end else begin
            fifo_wen <= mini_en;
            if (fifo_wen) fifo_wadr_mini <= fifo_wadr_mini + RAM_ADRB'(1);

            // RAM output is registered, so valid/last trail the address by one cycle.
            mini_rd_valid <= (state == READ);
            mini_rd_last  <= last_issue;
            mini_rd_done  <= (state == FLUSH) || (accept && (mini_tbins == '0));
            mini_rd_empty <= (state == IDLE) && rd_start && !evt_pending;
            mini_rd_busy  <= (state_next != IDLE);

            if (accept) begin
                fifo_radr_mini <= base_pending;
                word_cnt       <= '0;
                tbins_lat      <= mini_tbins;
            end else if ((state == READ) && !last_issue) begin
                fifo_radr_mini <= fifo_radr_mini + RAM_ADRB'(1);
                word_cnt       <= word_cnt + TBIN_BITS'(1);
            end

            // A trigger arriving as the pending event is consumed takes the freed slot.
            if (capture && (!evt_pending || accept)) begin
                base_pending <= new_base;
                evt_pending  <= 1'b1;
            end else if (accept) begin
                evt_pending  <= 1'b0;
            end
            evt_overflow <= capture && evt_pending && !accept;
        end
    end

`ifdef MINISCOPE_OVFCNT_EN
    logic [7:0] ovf_cnt_q;
    always_ff @(posedge clock) begin
        if (global_reset)
            ovf_cnt_q <= '0;
        else if (capture && evt_pending && !accept && (ovf_cnt_q != 8'hFF))
            ovf_cnt_q <= ovf_cnt_q + 8'd1;
    end
    assign overflow_cnt = ovf_cnt_q;
`else
    assign overflow_cnt = 8'd0;
`endif

endmodule
